// File: rtl/hpi_txn_ctrl.sv
// hpi_txn_ctrl: round-robin sequencer for single-word HPI read/write cycles
// from two requesters (port 0 = NIOS bridge, port 1 = USB poller), generating
// active-low CS/RD/WR/RST strobes with programmable setup/strobe/hold/recovery.
// Optional build macro HPI_TXN_COUNT_EN adds rd_count/wr_count ack counters.
module hpi_txn_ctrl #(
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned STROBE_CYC  = 4,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned RECOVER_CYC = 2,
  parameter int unsigned RST_CYC     = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [1:0]  addr0,
  input  logic [1:0]  addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic [1:0]  ack,
  output logic [15:0] rdata,
  input  logic        rst_req,
  output logic        busy,
  output logic [1:0]  hpi_address,
  output logic [15:0] hpi_data_out,
  input  logic [15:0] hpi_data_in,
  output logic        hpi_r,
  output logic        hpi_w,
  output logic        hpi_cs,
  output logic        hpi_reset
`ifdef HPI_TXN_COUNT_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RECOVER,
    CHIPRST
  } state_t;

  // Counters load N-1 and the phase ends when they reach zero.
  localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD  = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD    = 4'(HOLD_CYC - 1);
  localparam logic [3:0] RECOVER_LD = (RECOVER_CYC == 0) ? 4'd0 : 4'(RECOVER_CYC - 1);
  localparam logic [7:0] RST_LD     = 8'(RST_CYC - 1);
  localparam bit         NO_RECOVER = (RECOVER_CYC == 0);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic        rr_last_q, rr_last_d;
  logic        rst_pend_q, rst_pend_d;
  logic [1:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        cs_q, cs_d;
  logic        r_q, r_d;
  logic        w_q, w_d;
  logic        reset_q, reset_d;
  logic [1:0]  ack_q, ack_d;
  logic [15:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        g;
`ifdef HPI_TXN_COUNT_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
`endif

  // State and output registers; reset returns every strobe high at once.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rcnt_q     <= '0;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      rr_last_q  <= 1'b1;
      rst_pend_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cs_q       <= 1'b1;
      r_q        <= 1'b1;
      w_q        <= 1'b1;
      reset_q    <= 1'b1;
      ack_q      <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
`ifdef HPI_TXN_COUNT_EN
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rcnt_q     <= rcnt_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      rr_last_q  <= rr_last_d;
      rst_pend_q <= rst_pend_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cs_q       <= cs_d;
      r_q        <= r_d;
      w_q        <= w_d;
      reset_q    <= reset_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
`ifdef HPI_TXN_COUNT_EN
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
`endif
    end
  end

  // Next-state logic: arbitration, phase timing and registered strobe values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rcnt_d     = rcnt_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    rr_last_d  = rr_last_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cs_d       = cs_q;
    r_d        = r_q;
    w_d        = w_q;
    reset_d    = reset_q;
    ack_d      = '0;
    rdata_d    = rdata_q;
    g          = 1'b0;
    // A chip-reset request seen mid-transaction waits for the next IDLE.
    rst_pend_d = rst_pend_q | (rst_req & (state_q != IDLE));
`ifdef HPI_TXN_COUNT_EN
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (rst_req || rst_pend_q) begin
          state_d    = CHIPRST;
          reset_d    = 1'b0;
          rcnt_d     = RST_LD;
          rst_pend_d = 1'b0;
        end else if (req != 2'b00) begin
          g       = (req == 2'b11) ? ~rr_last_q : req[1];
          gnt_d   = g;
          we_d    = we[g];
          addr_d  = g ? addr1 : addr0;
          wdata_d = g ? wdata1 : wdata0;
          cs_d    = 1'b0;
          cnt_d   = SETUP_LD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LD;
          if (we_q) w_d = 1'b0;
          else      r_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
          r_d     = 1'b1;
          w_d     = 1'b1;
          // Interface data path is registered, so the last strobe-cycle
          // sample is presented at this edge.
          if (!we_q) rdata_d = hpi_data_in;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          cs_d         = 1'b1;
          ack_d[gnt_q] = 1'b1;
          rr_last_d    = gnt_q;
          cnt_d        = RECOVER_LD;
          state_d      = NO_RECOVER ? IDLE : RECOVER;
`ifdef HPI_TXN_COUNT_EN
          if (we_q) wr_cnt_d = wr_cnt_q + 16'd1;
          else      rd_cnt_d = rd_cnt_q + 16'd1;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RECOVER: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      CHIPRST: begin
        if (rcnt_q == 8'd0) begin
          reset_d = 1'b1;
          cnt_d   = RECOVER_LD;
          state_d = NO_RECOVER ? IDLE : RECOVER;
        end else begin
          rcnt_d = rcnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign ack          = ack_q;
  assign rdata        = rdata_q;
  assign busy         = busy_q;
  assign hpi_address  = addr_q;
  assign hpi_data_out = wdata_q;
  assign hpi_r        = r_q;
  assign hpi_w        = w_q;
  assign hpi_cs       = cs_q;
  assign hpi_reset    = reset_q;
`ifdef HPI_TXN_COUNT_EN
  assign rd_count     = rd_cnt_q;
  assign wr_count     = wr_cnt_q;
`endif

endmodule

// File: tb/tb_hpi_txn_ctrl.sv
// tb_hpi_txn_ctrl: scoreboard bench for hpi_txn_ctrl at default timing
// (setup 1, strobe 4, hold 1, recover 2, chip reset 16).
module tb_hpi_txn_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [1:0]  req, we, addr0, addr1, ack, hpi_address;
  logic [15:0] wdata0, wdata1, rdata, hpi_data_out, hpi_data_in;
  logic        rst_req, busy, hpi_r, hpi_w, hpi_cs, hpi_reset;
`ifdef HPI_TXN_COUNT_EN
  logic [15:0] rd_count, wr_count;
`endif

  typedef struct {
    logic        port;
    logic        wr;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  hpi_txn_ctrl #(
    .SETUP_CYC(1), .STROBE_CYC(4), .HOLD_CYC(1), .RECOVER_CYC(2), .RST_CYC(16)
  ) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .ack(ack), .rdata(rdata), .rst_req(rst_req),
    .busy(busy), .hpi_address(hpi_address), .hpi_data_out(hpi_data_out),
    .hpi_data_in(hpi_data_in), .hpi_r(hpi_r), .hpi_w(hpi_w), .hpi_cs(hpi_cs),
    .hpi_reset(hpi_reset)
`ifdef HPI_TXN_COUNT_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic ok, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
    end
  endtask

  // HPI interface model: presents the read word from the last strobe cycle
  // until CS rises, garbage otherwise.
  initial begin
    int rc;
    rc = 0;
    hpi_data_in = 16'hDEAD;
    forever begin
      @(negedge Clk);
      if (Reset || hpi_cs) begin
        rc = 0;
        hpi_data_in = 16'hDEAD;
      end else if (!hpi_r) begin
        rc++;
        if (rc == 4 && exp_q.size() > 0) hpi_data_in = exp_q[0].rdata;
      end
    end
  end

  // Monitor: measures strobe widths and gaps, pops the scoreboard on ack.
  initial begin
    int   cs_run, w_run, r_run, gap, rst_run, post_rst;
    bit   have_prev, addr_bad, data_bad;
    logic prev_cs, prev_rst;
    txn_t t;
    cs_run = 0; w_run = 0; r_run = 0; gap = 0; rst_run = 0; post_rst = 0;
    have_prev = 0; addr_bad = 0; data_bad = 0; prev_cs = 1; prev_rst = 1;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        chk("rst_strobes", {hpi_cs, hpi_r, hpi_w, hpi_reset} == 4'hF,
            32'({hpi_cs, hpi_r, hpi_w, hpi_reset}), 32'hF);
        chk("rst_ack_busy", {ack, busy} == 3'b000, 32'({ack, busy}), 0);
        chk("rst_addr_data", {hpi_address, hpi_data_out} == 18'd0,
            32'({hpi_address, hpi_data_out}), 0);
        chk("rst_rdata", rdata == 16'h0, 32'(rdata), 0);
        cs_run = 0; w_run = 0; r_run = 0; gap = 0; rst_run = 0; post_rst = 0;
        have_prev = 0; addr_bad = 0; data_bad = 0; prev_cs = 1; prev_rst = 1;
        continue;
      end
      if (ack != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 1'b0, 32'(ack), 0);
        end else begin
          t = exp_q.pop_front();
          chk("ack_port", ack == (t.port ? 2'b10 : 2'b01), 32'(ack),
              t.port ? 32'h2 : 32'h1);
          chk("ack_timing", !prev_cs && hpi_cs, 32'({prev_cs, hpi_cs}), 32'h1);
          if (!t.wr) chk("rdata", rdata == t.rdata, 32'(rdata), 32'(t.rdata));
          chk("cs_low_cycles", cs_run == 6, 32'(cs_run), 6);
          chk("wr_low_cycles", w_run == (t.wr ? 4 : 0), 32'(w_run), t.wr ? 4 : 0);
          chk("rd_low_cycles", r_run == (t.wr ? 0 : 4), 32'(r_run), t.wr ? 0 : 4);
          chk("addr_stable", !addr_bad, 32'(addr_bad), 0);
          chk("wdata_stable", !data_bad, 32'(data_bad), 0);
        end
        cs_run = 0; w_run = 0; r_run = 0; addr_bad = 0; data_bad = 0;
        gap = 1; have_prev = 1;
      end else begin
        if (!hpi_cs) begin
          cs_run++;
          if (exp_q.size() > 0) begin
            if (hpi_address != exp_q[0].addr) addr_bad = 1;
            if (hpi_data_out != exp_q[0].wdata) data_bad = 1;
          end
          if (prev_cs) begin
            if (have_prev) chk("cs_gap", gap >= 2, 32'(gap), 2);
            // After chip reset: two RECOVER cycles plus the IDLE grant cycle.
            if (post_rst > 0) begin
              chk("grant_after_recover", post_rst == 3, 32'(post_rst), 3);
              post_rst = 0;
            end
          end
        end else begin
          gap++;
          if (post_rst > 0) post_rst++;
        end
        if (!hpi_w) w_run++;
        if (!hpi_r) r_run++;
      end
      if (!hpi_reset) begin
        rst_run++;
        if (prev_rst) chk("chip_rst_outside_txn", hpi_cs, 32'(hpi_cs), 1);
      end else if (!prev_rst) begin
        chk("chip_rst_cycles", rst_run == 16, 32'(rst_run), 16);
        rst_run = 0;
        post_rst = 1;
      end
      prev_cs = hpi_cs;
      prev_rst = hpi_reset;
    end
  end

  task automatic push(input logic p, input logic w, input logic [1:0] a,
                      input logic [15:0] wd, input logic [15:0] rd);
    txn_t t;
    t.port = p; t.wr = w; t.addr = a; t.wdata = wd; t.rdata = rd;
    exp_q.push_back(t);
  endtask

  task automatic wait_acks(input int n, input logic [1:0] drop_mask);
    int got;
    got = 0;
    for (int i = 0; i < 300 * n && got < n; i++) begin
      @(negedge Clk);
      if (ack != 2'b00) begin
        got++;
        req = req & ~(ack & drop_mask);
      end
    end
    chk("acks_received", got == n, 32'(got), 32'(n));
  endtask

  task automatic do_txn(input logic p, input logic w, input logic [1:0] a,
                        input logic [15:0] wd, input logic [15:0] rd);
    we[p] = w;
    if (p) begin addr1 = a; wdata1 = wd; end
    else   begin addr0 = a; wdata0 = wd; end
    push(p, w, a, wd, rd);
    req[p] = 1'b1;
    wait_acks(1, 2'b11);
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    req = '0; we = '0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    rst_req = 1'b0;
    #1 Reset = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    // Basic write from port 0, then read on port 1.
    do_txn(1'b0, 1'b1, 2'd2, 16'h1234, 16'h0000);
    do_txn(1'b1, 1'b0, 2'd1, 16'h0000, 16'hBEEF);

    // Both requesting continuously: rr_last=1 so order is 0,1,0,1.
    we = 2'b01; addr0 = 2'd3; wdata0 = 16'h0F0F; addr1 = 2'd2; wdata1 = 16'h0000;
    push(1'b0, 1'b1, 2'd3, 16'h0F0F, 16'h0000);
    push(1'b1, 1'b0, 2'd2, 16'h0000, 16'h1111);
    push(1'b0, 1'b1, 2'd3, 16'h0F0F, 16'h0000);
    push(1'b1, 1'b0, 2'd2, 16'h0000, 16'h2222);
    req = 2'b11;
    wait_acks(4, 2'b00);
    req = 2'b00;
    repeat (4) @(negedge Clk);

    // Chip reset requested during a port 0 read; port 1 waits behind it.
    we = 2'b10; addr0 = 2'd3; wdata0 = 16'h7777;
    push(1'b0, 1'b0, 2'd3, 16'h7777, 16'h5A5A);
    req = 2'b01;
    for (int i = 0; i < 50 && hpi_cs; i++) @(negedge Clk);
    chk("grant_seen", !hpi_cs, 32'(hpi_cs), 0);
    rst_req = 1'b1;
    addr1 = 2'd0; wdata1 = 16'hA5A5;
    push(1'b1, 1'b1, 2'd0, 16'hA5A5, 16'h0000);
    req = 2'b11;
    @(negedge Clk);
    rst_req = 1'b0;
    wait_acks(2, 2'b11);
    repeat (4) @(negedge Clk);

    // Reset asserted mid-strobe: aborted write must not ack.
    we = 2'b01; addr0 = 2'd1; wdata0 = 16'hCAFE;
    req = 2'b01;
    for (int i = 0; i < 50 && hpi_w; i++) @(negedge Clk);
    chk("strobe_seen", !hpi_w, 32'(hpi_w), 0);
    @(posedge Clk);
    #1 Reset = 1'b1;
    req = 2'b00;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    // Normal traffic after reset: 3 writes, 2 reads.
    do_txn(1'b0, 1'b1, 2'd0, 16'h0001, 16'h0000);
    do_txn(1'b1, 1'b0, 2'd3, 16'h0000, 16'h3C3C);
    do_txn(1'b0, 1'b1, 2'd1, 16'hFFFF, 16'h0000);
    do_txn(1'b1, 1'b0, 2'd2, 16'h0000, 16'h8001);
    do_txn(1'b0, 1'b1, 2'd3, 16'h5555, 16'h0000);
`ifdef HPI_TXN_COUNT_EN
    chk("wr_count", wr_count == 16'd3, 32'(wr_count), 3);
    chk("rd_count", rd_count == 16'd2, 32'(rd_count), 2);
`endif

    repeat (5) @(negedge Clk);
    chk("scoreboard_drained", exp_q.size() == 0, 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hpi_txn_ctrl.md
Name: hpi_txn_ctrl

Overview:
Sequences single-word HPI read/write cycles to the EZ-OTG host-port interface logic on behalf of two requesters. Port 0 is the NIOS software bridge and port 1 is the USB polling engine; they share the port through round-robin arbitration. The block generates the active-low CS/RD/WR/RST strobes with programmable setup, strobe, hold and recovery timing, and captures read data. It sits between the requesters and the HPI I/O interface, whose control and data-in paths are each registered with one cycle of latency.

Parameters:
SETUP_CYC, 1, cycles CS asserted with address stable before the RD/WR strobe (1..15)
STROBE_CYC, 4, cycles RD_N or WR_N held low (1..15)
HOLD_CYC, 1, cycles CS/address/data held after the strobe deasserts (1..15)
RECOVER_CYC, 2, idle cycles with CS high between transactions (0..15)
RST_CYC, 16, cycles the chip reset is held low for a reset request (1..255)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
req  in  2  per-requester request; level, held until ack
we  in  2  per-requester write enable (1 = write)
addr0, addr1  in  2 each  HPI register address per requester
wdata0, wdata1  in  16 each  write data per requester
ack  out  2  one-cycle done pulse, one-hot
rdata  out  16  read data; valid in the cycle ack pulses, held until the next read
rst_req  in  1  chip-reset request; pulse
busy  out  1  high whenever state != IDLE
hpi_address  out  2  to HPI interface address
hpi_data_out  out  16  to HPI interface write data
hpi_data_in  in  16  registered OTG data from the HPI interface
hpi_r, hpi_w, hpi_cs, hpi_reset  out  1 each  active-low strobes to the HPI interface

Behaviour:
- Reset (async): state IDLE; hpi_r/hpi_w/hpi_cs/hpi_reset = 1; hpi_address = 0; hpi_data_out = 0; ack = 0; rdata = 0; busy = 0; rr_last = 1, so port 0 wins first.
- A reset asserted mid-transaction aborts it immediately: strobes return high and no ack is issued.
- All outputs are registered.
- States: IDLE, SETUP, STROBE, HOLD, RECOVER, CHIPRST. A 4-bit down-counter `cnt` times SETUP/STROBE/HOLD/RECOVER; an 8-bit counter times CHIPRST.
- IDLE:
  - rst_req has priority over any req: go to CHIPRST with hpi_reset = 0.
  - Otherwise, if any req bit is set, grant round-robin: with both requesting, grant = ~rr_last.
  - On grant, latch addr/we/wdata of the granted port into hpi_address/hpi_data_out, set hpi_cs = 0, go to SETUP.
- SETUP: lasts SETUP_CYC cycles, then go to STROBE. On entry to STROBE, hpi_r = 0 if read, or hpi_w = 0 if write.
- STROBE: lasts STROBE_CYC cycles. On exit, deassert the strobe. For a read, hpi_data_in is captured into rdata on the first HOLD cycle edge; this compensates for the interface's 1-cycle data register.
- HOLD: lasts HOLD_CYC cycles. On exit:
  - hpi_cs = 1;
  - ack[g] pulses for one cycle;
  - rr_last = g;
  - go to RECOVER, or to IDLE if RECOVER_CYC == 0.
- RECOVER: lasts RECOVER_CYC cycles, then go to IDLE.
- CHIPRST: hpi_reset stays 0 for RST_CYC cycles, then returns to 1; go to RECOVER. No ack is issued. rst_req arriving while not IDLE is latched and serviced at the next IDLE.
- Write data: hpi_data_out stays stable from SETUP through HOLD. The interface tristates OTG_DATA while hpi_w = 1.
- Request/ack rules:
  - A requester must drop req the cycle after ack; otherwise it re-requests.
  - A req that drops before its grant is ignored; behaviour after a mid-transaction drop is undefined.
- Minimum transaction length: SETUP_CYC + STROBE_CYC + HOLD_CYC + 1 cycles from grant to ack.

Optional Feature:
HPI_TXN_COUNT_EN:
- Defined: adds outputs rd_count[15:0] and wr_count[15:0]. They increment on each read/write ack, wrap from 0xFFFF to 0, and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- After reset, default parameters, port 0 write addr=2, wdata=0x1234 -> hpi_cs low for 6 cycles, hpi_w low for exactly 4 cycles, hpi_address=2 and hpi_data_out=0x1234 stable throughout, ack=01 at cycle 7 after grant.
- Port 1 read addr=1, with hpi_data_in driven to 0xBEEF during the last strobe cycle -> rdata=0xBEEF when ack=10; hpi_w stays 1 throughout.
- Both req held continuously, 4 transactions -> grants alternate 0,1,0,1; at least 2 cycles with hpi_cs high between transactions.
- rst_req pulsed during a port 0 read -> the read completes with ack, then hpi_reset is low for 16 cycles; a pending req is granted only after the subsequent RECOVER.
- Reset asserted during STROBE -> all strobes high asynchronously, no ack, busy=0; the next request runs normally.
- With HPI_TXN_COUNT_EN defined, 3 writes and 2 reads -> wr_count=3, rd_count=2; preload near 0xFFFF and verify wrap to 0.
